// File: rtl/conv_mul_pkg.sv
// Shared types and width helpers for the conv-kernel shared multiplier.
package conv_mul_pkg;

   localparam int A_W_DEF  = 16;
   localparam int B_W_DEF  = 8;
   localparam int P_W_DEF  = A_W_DEF + B_W_DEF;
   localparam int ID_MAX_W = 4;

   typedef struct packed {
      logic [ID_MAX_W-1:0]       id;
      logic signed [A_W_DEF-1:0] a;
      logic signed [B_W_DEF-1:0] b;
   } mul_op_t;

   typedef struct packed {
      logic [ID_MAX_W-1:0]       id;
      logic signed [P_W_DEF-1:0] p;
   } mul_res_t;

   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_mul_rr_arb.sv
// Combinational round-robin grant with a registered search pointer.
module conv_mul_rr_arb #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] ptr;
   logic          found;

   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
      gnt = found ? (N'(1) << idx) : '0;
   end

   // pointer moves past the winner only on an actual handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (en && found) begin
         ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/conv_mul_share_arb.sv
// Round-robin shared signed multiplier with tagged result stream.
// Define CONV_MUL_SHARE_ARB_PIPE_EN to add an output (PREG) stage.
module conv_mul_share_arb
   import conv_mul_pkg::*;
#(
   parameter int   NUM_REQ = 4,
   parameter int   A_W     = A_W_DEF,
   parameter int   B_W     = B_W_DEF,
   localparam int  P_W     = A_W + B_W,
   localparam int  ID_W    = id_w(NUM_REQ)
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [P_W-1:0]         rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy
);

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gidx;
   logic               s1_ld, s2_ld, hs;

   logic               s1_v;
   logic [A_W-1:0]     s1_a;
   logic [B_W-1:0]     s1_b;
   logic [ID_W-1:0]    s1_id;
   logic               s2_v;
   logic [P_W-1:0]     s2_p;
   logic [ID_W-1:0]    s2_id;
   logic [P_W-1:0]     prod;

   conv_mul_rr_arb #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_arb (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .req   (req_valid),
      .en    (s1_ld & ap_rst_n),
      .gnt   (gnt),
      .idx   (gidx)
   );

   assign req_ready = gnt & {NUM_REQ{s1_ld & ap_rst_n}};
   assign hs        = |req_ready;
   assign s1_ld     = !s1_v || s2_ld;

   // operands sign-extended to full product width for an exact result
   assign prod = $signed({{B_W{s1_a[A_W-1]}}, s1_a})
               * $signed({{A_W{s1_b[B_W-1]}}, s1_b});

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         s1_v  <= 1'b0;
         s1_a  <= '0;
         s1_b  <= '0;
         s1_id <= '0;
      end else if (s1_ld) begin
         s1_v <= hs;
         if (hs) begin
            s1_a  <= req_a[gidx*A_W +: A_W];
            s1_b  <= req_b[gidx*B_W +: B_W];
            s1_id <= gidx;
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         s2_v  <= 1'b0;
         s2_p  <= '0;
         s2_id <= '0;
      end else if (s2_ld) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_p  <= prod;
            s2_id <= s1_id;
         end
      end
   end

`ifdef CONV_MUL_SHARE_ARB_PIPE_EN
   logic            s3_v, s3_ld;
   logic [P_W-1:0]  s3_p;
   logic [ID_W-1:0] s3_id;

   assign s3_ld = !s3_v || rsp_ready;
   assign s2_ld = !s2_v || s3_ld;

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         s3_v  <= 1'b0;
         s3_p  <= '0;
         s3_id <= '0;
      end else if (s3_ld) begin
         s3_v <= s2_v;
         if (s2_v) begin
            s3_p  <= s2_p;
            s3_id <= s2_id;
         end
      end
   end

   assign rsp_valid = s3_v;
   assign rsp_data  = s3_p;
   assign rsp_id    = s3_id;
   assign busy      = s1_v | s2_v | s3_v;
`else
   assign s2_ld     = !s2_v || rsp_ready;
   assign rsp_valid = s2_v;
   assign rsp_data  = s2_p;
   assign rsp_id    = s2_id;
   assign busy      = s1_v | s2_v;
`endif

endmodule

// File: tb/tb_conv_mul_share_arb.sv
// Randomized bench for conv_mul_share_arb against a timed-queue model.
module tb_conv_mul_share_arb;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int BW = 8;
   localparam int PW = 24;
`ifdef CONV_MUL_SHARE_ARB_PIPE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic            ap_clk = 1'b0;
   logic            ap_rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_a;
   logic [N*BW-1:0] req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [PW-1:0]   rsp_data;
   logic [1:0]      rsp_id;
   logic            busy;

   conv_mul_share_arb dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      int     id;
      longint p;
      int     acc;
   } item_t;

   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;
   int    ptr      = 0;
   int    last_dep = -100;
   item_t q[$];
   int    va[N];
   int    aa[N];
   int    bb[N];

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = (va[i] != 0);
         req_a[i*AW +: AW]    = AW'(aa[i]);
         req_b[i*BW +: BW]    = BW'(bb[i]);
      end
   endtask

   task automatic set_req(input int i, input int a, input int b);
      va[i] = 1;
      aa[i] = a;
      bb[i] = b;
   endtask

   task automatic new_ops(input int i);
      logic signed [AW-1:0] ra;
      logic signed [BW-1:0] rb;
      ra = AW'($urandom);
      rb = BW'($urandom);
      set_req(i, int'(ra), int'(rb));
   endtask

   task automatic refill();
      for (int i = 0; i < N; i++)
         if (va[i] == 0) new_ops(i);
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) va[i] = 0;
   endtask

   // one clock: model decides grant/ready/result, DUT compared at negedge
   task automatic tick();
      logic [N-1:0] er;
      int           g;
      int           pt;
      bit           can;
      bit           ev;
      drive();
      @(negedge ap_clk);
      if (!ap_rst_n) begin
         chk("ready_in_reset", longint'(req_ready), 0);
         q.delete();
         ptr      = 0;
         last_dep = -100;
      end else begin
         can = (q.size() < LAT) || rsp_ready;
         g   = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && va[(ptr + k) % N] != 0) g = (ptr + k) % N;
         er = '0;
         if (can && g >= 0) er[g] = 1'b1;
         chk("req_ready", longint'(req_ready), longint'(er));
         chk("busy", longint'(busy), longint'(q.size() > 0));
         ev = 1'b0;
         if (q.size() > 0) begin
            pt = q[0].acc + LAT;
            if (last_dep + 1 > pt) pt = last_dep + 1;
            ev = (pt <= cyc);
         end
         chk("rsp_valid", longint'(rsp_valid), longint'(ev));
         if (ev) begin
            chk("rsp_id", longint'(rsp_id), longint'(q[0].id));
            chk("rsp_data", longint'($signed(rsp_data)), q[0].p);
            if (rsp_ready) begin
               void'(q.pop_front());
               last_dep = cyc;
            end
         end
         if (er != '0) begin
            q.push_back('{g, longint'(aa[g]) * longint'(bb[g]), cyc});
            ptr   = (g + 1) % N;
            va[g] = 0;
         end
      end
      @(posedge ap_clk);
      #1;
      cyc++;
   endtask

   task automatic rand_step();
      rsp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
         if (va[i] == 0 && ($urandom % 3) == 0) begin
            if (($urandom % 8) == 0)
               set_req(i, (($urandom % 2) == 0) ? -32768 : 32767,
                       (($urandom % 2) == 0) ? -128 : 127);
            else
               new_ops(i);
         end else if (va[i] != 0 && ($urandom % 20) == 0) begin
            va[i] = 0;
         end
      end
   endtask

   initial begin
      ap_rst_n  = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < N; i++) begin
         va[i] = 0;
         aa[i] = 0;
         bb[i] = 0;
      end
      repeat (2) tick();
      ap_rst_n = 1'b1;
      chk("rst_valid", longint'(rsp_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_data", longint'(rsp_data), 0);
      chk("rst_id", longint'(rsp_id), 0);

      set_req(2, 300, -5);
      tick();
      repeat (LAT + 1) tick();

      set_req(0, -32768, -128);
      set_req(1, 32767, -128);
      set_req(2, 0, 127);
      repeat (LAT + 4) tick();

      repeat (12) begin refill(); tick(); end
      rsp_ready = 1'b0;
      repeat (5) begin refill(); tick(); end
      rsp_ready = 1'b1;
      repeat (8) begin refill(); tick(); end
      clear_all();
      repeat (LAT + 2) tick();

      set_req(2, 11, 3);
      tick();
      set_req(1, -7, 9);
      tick();
      set_req(0, 123, -45);
      set_req(3, -1000, 100);
      tick();
      tick();
      repeat (LAT + 2) tick();

      rsp_ready = 1'b0;
      repeat (4) begin refill(); tick(); end
      ap_rst_n = 1'b0;
      tick();
      ap_rst_n = 1'b1;
      chk("midrst_valid", longint'(rsp_valid), 0);
      chk("midrst_busy", longint'(busy), 0);
      clear_all();
      rsp_ready = 1'b1;
      set_req(0, 500, 50);
      set_req(3, -2, -3);
      tick();
      repeat (LAT + 2) tick();

      repeat (1500) begin rand_step(); tick(); end
      clear_all();
      rsp_ready = 1'b1;
      repeat (LAT + 8) tick();
      chk("drained", longint'(q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_mul_share_arb.md
Name: conv_mul_share_arb

Overview:
- Time-shares one signed 16x8 multiplier among NUM_REQ conv-kernel requesters; sits between the per-tap operand generators and the shared DSP48 product path.
- Round-robin arbitration, per-requester valid/ready operand handshake, pipelined multiply, single tagged result stream with backpressure.
- Default latency is 2 cycles from grant to rsp_valid.

Parameters:
- NUM_REQ, 4, number of requesters (1..16)
- A_W, 16, signed operand A width
- B_W, 8, signed operand B width
- Localparams, not overridable: P_W = A_W+B_W (24); ID_W = max(1, clog2(NUM_REQ))

Ports:
- ap_clk  in  1  clock; all state on rising edge
- ap_rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*A_W  packed operand A; requester i at [i*A_W +: A_W]
- req_b  in  NUM_REQ*B_W  packed operand B; requester i at [i*B_W +: B_W]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accept
- rsp_data  out  P_W  signed product a*b
- rsp_id  out  ID_W  index of the requester that produced rsp_data
- busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (ap_rst_n=0 at edge): all stage valids 0, RR pointer 0, data/id registers 0. Outputs: rsp_valid=0, rsp_data=0, rsp_id=0, busy=0. req_ready=0 while ap_rst_n=0.
- Reset mid-operation: in-flight products are discarded, not replayed. Requesters must re-present.
- Pipeline:
  - S1 registers the granted a, b and id.
  - S2 registers the full-precision signed product $signed(a)*$signed(b) (P_W bits, no truncation or saturation) plus id.
  - S2 drives rsp_*.
- Advance rules:
  - S2 loads when S2 is empty or rsp_ready=1.
  - S1 loads when S1 is empty or S1 advances into S2.
  - Bubbles collapse; throughput is 1 result/cycle with rsp_ready held high.
- Arbitration:
  - Combinational and round-robin. The search starts at the pointer and takes the first i with req_valid[i]=1.
  - req_ready[g]=1 only if S1 can load this cycle.
  - A handshake (valid & ready) sets pointer = (g+1) mod NUM_REQ.
  - With no handshake the pointer holds.
  - Pointer wraps from NUM_REQ-1 to 0.
- Handshake rules:
  - A requester holds valid and operands stable until ready.
  - req_ready may depend combinationally on req_valid and rsp_ready.
  - req_valid must not depend on req_ready.
- Backpressure: with rsp_ready=0 and S2 full, S1 fills and then all req_ready=0. No data is lost or duplicated.
- Simultaneous events:
  - Same-cycle S2 drain and S1 reload are both performed.
  - A requester dropping valid while not granted is legal, and the pointer is unaffected.
- NUM_REQ=1: rsp_id constant 0; grant whenever S1 can load.
- busy = S1 valid OR S2 valid (OR S3 valid when the optional stage is present).

Optional Feature:
- Macro: CONV_MUL_SHARE_ARB_PIPE_EN.
- Defined: adds S3, a registered copy of the S2 product/id mapped to the DSP48 PREG. Latency becomes 3; rsp_* are driven from S3. The same advance rule applies per stage, so throughput is unchanged.
- Undefined: 2-stage pipeline as above.

Decomposition:
- Shared package conv_mul_pkg holds:
  - the A_W/B_W/P_W defaults
  - typedef of the {id, a, b} operand bundle
  - typedef of the {id, p} result bundle
  - the clog2-based ID_W function
- One sub-module, conv_mul_rr_arb: combinational round-robin grant plus pointer register (inputs: req vector, accept enable; outputs: one-hot grant, grant index).
- The multiplier stays inline as a signed multiply so that synthesis infers DSP48.

Test Plan:
- Single requester, rsp_ready=1: req 2 presents a=300, b=-5 at cycle 0 → req_ready[2]=1 at cycle 0; rsp_valid=1, rsp_id=2, rsp_data=-1500 (0xFFFA24) at cycle 2.
- All 4 valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1… one per cycle, with no gaps after the first 2 fill cycles.
- Signed corners:
  - a=-32768, b=-128 → 4194304 (0x400000)
  - a=32767, b=-128 → -4194176 (0xC00080)
  - a=0, b=127 → 0
- Backpressure: rsp_ready=0 for 5 cycles under full load → after 2 accepts all req_ready=0, and rsp_data/rsp_id are held stable. On release, results emerge in grant order with no loss or duplication.
- Pointer wrap with sparse requests: pointer=3 and only req 1 valid → grant 1, pointer becomes 2. Next, req 0 and req 3 valid → grant 3, then 0.
- Reset mid-flight: ap_rst_n=0 for 1 cycle with S1 and S2 full → next cycle rsp_valid=0, busy=0, pointer 0. A subsequent request returns after exactly 2 cycles (3 with CONV_MUL_SHARE_ARB_PIPE_EN).
